// File: rtl/snake_collision_if.sv
`default_nettype none
// ============================================================================
// Module   : snake_collision_if
// Brief    : Check/segment-stream/result bundle for snake_collision_unit.
// Revision : 1.0
// ============================================================================
interface snake_collision_if;
  logic       check_start;
  logic [7:0] head_x;
  logic [6:0] head_y;
  logic       seg_valid;
  logic [7:0] seg_x;
  logic [6:0] seg_y;
  logic       seg_last;
  logic       busy;
  logic       check_done;
  logic       is_dead;
  logic       length_inc;
  logic [7:0] food_x;
  logic [6:0] food_y;

  modport master (
    output check_start, head_x, head_y, seg_valid, seg_x, seg_y, seg_last,
    input  busy, check_done, is_dead, length_inc, food_x, food_y
  );

  modport slave (
    input  check_start, head_x, head_y, seg_valid, seg_x, seg_y, seg_last,
    output busy, check_done, is_dead, length_inc, food_x, food_y
  );
endinterface
`default_nettype wire

// File: rtl/snake_collision_unit.sv
`default_nettype none
// ============================================================================
// Module   : snake_collision_unit
// Brief    : Wall/self/food collision check with LFSR-driven food relocation.
// Revision : 1.0
// ============================================================================
module snake_collision_unit #(
  parameter int          SCR_W     = 160,
  parameter int          SCR_H     = 120,
  parameter int          FOOD_X0   = 80,
  parameter int          FOOD_Y0   = 60,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 255
) (
  input  logic             clk,
  input  logic             rst,
  snake_collision_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SCAN     = 2'd1,
    S_RESOLVE  = 2'd2,
    S_RELOCATE = 2'd3
  } state_t;

  localparam int         c_try_w   = $clog2(MAX_TRIES + 1);
  localparam logic [8:0] c_scr_w   = 9'(SCR_W);
  localparam logic [7:0] c_scr_h   = 8'(SCR_H);
  localparam logic [6:0] c_cells_x = 7'(SCR_W / 4);
  localparam logic [5:0] c_cells_y = 6'(SCR_H / 4);
  localparam logic [7:0] c_food_x0 = 8'(FOOD_X0);
  localparam logic [6:0] c_food_y0 = 7'(FOOD_Y0);
  localparam logic [c_try_w-1:0] c_try_last = c_try_w'(MAX_TRIES - 1);

  state_t               r_state;
  logic [15:0]          r_lfsr;
  logic [7:0]           r_head_x;
  logic [6:0]           r_head_y;
  logic                 r_dead;
  logic [c_try_w-1:0]   r_tries;
  logic [7:0]           r_food_x;
  logic [6:0]           r_food_y;
  logic                 r_busy;
  logic                 r_check_done;
  logic                 r_is_dead;
  logic                 r_length_inc;

  logic                 w_fb;
  logic [5:0]           w_cx;
  logic [4:0]           w_cy;
  logic [7:0]           w_cand_x;
  logic [6:0]           w_cand_y;
  logic                 w_cand_ok;
  logic                 w_wall_hit;
  logic                 w_seg_hit;

  assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cx       = r_lfsr[5:0];
  assign w_cy       = r_lfsr[12:8];
  assign w_cand_x   = {w_cx, 2'b00};
  assign w_cand_y   = {w_cy, 2'b00};
  assign w_cand_ok  = ({1'b0, w_cx} < c_cells_x) && ({1'b0, w_cy} < c_cells_y) &&
                      !((w_cand_x == r_head_x) && (w_cand_y == r_head_y));
  // Coordinates that went negative wrap high, so the range test covers both edges
  assign w_wall_hit = ({1'b0, bus.head_x} >= c_scr_w) || ({1'b0, bus.head_y} >= c_scr_h);
  assign w_seg_hit  = (bus.seg_x == r_head_x) && (bus.seg_y == r_head_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_head_x     <= '0;
      r_head_y     <= '0;
      r_dead       <= 1'b0;
      r_tries      <= '0;
      r_food_x     <= c_food_x0;
      r_food_y     <= c_food_y0;
      r_busy       <= 1'b0;
      r_check_done <= 1'b0;
      r_is_dead    <= 1'b0;
      r_length_inc <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[14:0], w_fb};
      r_check_done <= 1'b0;
      r_is_dead    <= 1'b0;
      r_length_inc <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.check_start) begin
            r_head_x <= bus.head_x;
            r_head_y <= bus.head_y;
            r_dead   <= w_wall_hit;
            r_tries  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SCAN;
          end
        end

        S_SCAN: begin
          // The full stream is always drained so the body walker stays in step
          if (bus.seg_valid) begin
            if (w_seg_hit) begin
              r_dead <= 1'b1;
            end
            if (bus.seg_last) begin
              r_state <= S_RESOLVE;
            end
          end
        end

        S_RESOLVE: begin
          if (r_dead) begin
            r_check_done <= 1'b1;
            r_is_dead    <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if ((r_head_x == r_food_x) && (r_head_y == r_food_y)) begin
            r_state <= S_RELOCATE;
          end else begin
            r_check_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end

        S_RELOCATE: begin
          if (w_cand_ok) begin
            r_food_x     <= w_cand_x;
            r_food_y     <= w_cand_y;
            r_check_done <= 1'b1;
            r_length_inc <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (r_tries == c_try_last) begin
            r_food_x     <= c_food_x0;
            r_food_y     <= c_food_y0;
            r_check_done <= 1'b1;
            r_length_inc <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_tries <= r_tries + 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.check_done = r_check_done;
  assign bus.is_dead    = r_is_dead;
  assign bus.length_inc = r_length_inc;
  assign bus.food_x     = r_food_x;
  assign bus.food_y     = r_food_y;

endmodule
`default_nettype wire

// File: tb/tb_snake_collision_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_collision_unit
// Brief    : Scoreboard bench for snake_collision_unit with LFSR food model.
// Revision : 1.0
// ============================================================================
module tb_snake_collision_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_collision_if bus();

  snake_collision_unit #(
    .SCR_W(160), .SCR_H(120), .FOOD_X0(80), .FOOD_Y0(60),
    .LFSR_SEED(16'hACE1), .MAX_TRIES(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      name;
    bit         dead;
    bit         inc;
    logic [7:0] fx;
    logic [6:0] fy;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic       rst_q  = 1'b1;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [7:0] m_fx = 8'd80;
  logic [6:0] m_fy = 7'd60;
  logic [7:0] prev_fx = 8'd80;
  logic [6:0] prev_fy = 7'd60;
  logic [7:0] sx[$];
  logic [6:0] sy[$];

  function automatic logic [15:0] nxt(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_q  <= rst;
    m_lfsr <= rst ? 16'hACE1 : nxt(m_lfsr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a completed check
  always @(negedge clk) begin
    if (!rst_q) begin
      if (bus.check_done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done: got check_done=1, expected none (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_is_dead"},    bus.is_dead,    e.dead);
          chk({e.name, "_length_inc"}, bus.length_inc, e.inc);
          chk({e.name, "_food_x"},     bus.food_x,     e.fx);
          chk({e.name, "_food_y"},     bus.food_y,     e.fy);
          chk({e.name, "_done_cycle"}, cyc,            e.cyc);
          chk({e.name, "_busy_fall"},  bus.busy,       1'b0);
          chk({e.name, "_food_align"}, {bus.food_x[1:0], bus.food_y[1:0]}, 4'd0);
          chk({e.name, "_food_range"}, {bus.food_x < 8'd160, bus.food_y < 7'd120}, 2'b11);
        end
      end else if (bus.is_dead || bus.length_inc) begin
        checks++; errors++;
        $display("FAIL orphan_pulse: got is_dead=%0d length_inc=%0d, expected 0 without check_done",
                 bus.is_dead, bus.length_inc);
      end
      if (((bus.food_x != prev_fx) || (bus.food_y != prev_fy)) && !bus.length_inc) begin
        checks++; errors++;
        $display("FAIL food_stable: got (%0d,%0d), expected (%0d,%0d)",
                 bus.food_x, bus.food_y, prev_fx, prev_fy);
      end
    end
    prev_fx = bus.food_x;
    prev_fy = bus.food_y;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one check against the segment list in sx/sy; the start cycle carries
  // a matching, last-flagged segment that must be ignored.
  task automatic do_check(input string name, input logic [7:0] hx, input logic [6:0] hy,
                          input bit exp_dead, input bit poke);
    int          s;
    logic [15:0] l;
    exp_t        e;
    bus.check_start = 1'b1;
    bus.head_x      = hx;
    bus.head_y      = hy;
    bus.seg_valid   = 1'b1;
    bus.seg_x       = hx;
    bus.seg_y       = hy;
    bus.seg_last    = 1'b1;
    tick();
    bus.check_start = 1'b0;
    chk({name, "_busy_rise"}, bus.busy, 1'b1);
    s = 0;
    l = '0;
    for (int i = 0; i < sx.size(); i++) begin
      if (i == 1) begin
        bus.seg_valid = 1'b0;
        bus.seg_last  = 1'b0;
        tick();
      end
      bus.seg_valid = 1'b1;
      bus.seg_x     = sx[i];
      bus.seg_y     = sy[i];
      bus.seg_last  = (i == sx.size() - 1);
      if (poke && i == 1) begin
        bus.check_start = 1'b1;
        bus.head_x      = 8'd0;
        bus.head_y      = 7'd0;
      end
      if (i == sx.size() - 1) begin
        s = cyc;
        l = m_lfsr;
      end
      tick();
      bus.check_start = 1'b0;
    end
    bus.seg_valid = 1'b0;
    bus.seg_last  = 1'b0;

    e.name = name;
    e.dead = exp_dead;
    e.inc  = 1'b0;
    e.cyc  = s + 2;
    if (!exp_dead && hx == m_fx && hy == m_fy) begin
      logic [15:0] v;
      int          k;
      bit          done;
      v    = nxt(nxt(l));
      k    = 1;
      done = 1'b0;
      while (!done) begin
        if (v[5:0] < 6'd40 && v[12:8] < 5'd30 &&
            !({v[5:0], 2'b00} == hx && {v[12:8], 2'b00} == hy)) begin
          m_fx = {v[5:0], 2'b00};
          m_fy = {v[12:8], 2'b00};
          done = 1'b1;
        end else if (k == 255) begin
          m_fx = 8'd80;
          m_fy = 7'd60;
          done = 1'b1;
        end else begin
          v = nxt(v);
          k++;
        end
      end
      e.inc = 1'b1;
      e.cyc = s + 2 + k;
    end
    e.fx = m_fx;
    e.fy = m_fy;
    sb.push_back(e);

    for (int w = 0; w < 600 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no check_done, expected one within 600 cycles", name);
      sb.delete();
    end
    #1;
    repeat (3) tick();
  endtask

  task automatic set_segs3(input logic [7:0] x0, input logic [6:0] y0,
                           input logic [7:0] x1, input logic [6:0] y1,
                           input logic [7:0] x2, input logic [6:0] y2);
    sx.delete(); sy.delete();
    sx.push_back(x0); sy.push_back(y0);
    sx.push_back(x1); sy.push_back(y1);
    sx.push_back(x2); sy.push_back(y2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    bus.check_start = 1'b0;
    bus.head_x      = '0;
    bus.head_y      = '0;
    bus.seg_valid   = 1'b0;
    bus.seg_x       = '0;
    bus.seg_y       = '0;
    bus.seg_last    = 1'b0;
    rst             = 1'b1;
    repeat (2) tick();
    chk("rst_food_x", bus.food_x, 8'd80);
    chk("rst_food_y", bus.food_y, 7'd60);
    chk("rst_pulses", {bus.busy, bus.check_done, bus.is_dead, bus.length_inc}, 4'd0);
    rst = 1'b0;
    repeat (2) tick();

    set_segs3(8'd12, 7'd8, 8'd16, 7'd8, 8'd20, 7'd8);
    do_check("wall_x160", 8'd160, 7'd20, 1'b1, 1'b0);
    do_check("wall_underflow", 8'd252, 7'd0, 1'b1, 1'b0);
    do_check("wall_y120", 8'd0, 7'd120, 1'b1, 1'b0);

    set_segs3(8'd44, 7'd40, 8'd40, 7'd40, 8'd36, 7'd40);
    do_check("self_hit", 8'd40, 7'd40, 1'b1, 1'b0);
    set_segs3(8'd44, 7'd40, 8'd48, 7'd40, 8'd40, 7'd40);
    do_check("self_hit_last", 8'd40, 7'd40, 1'b1, 1'b0);

    set_segs3(8'd24, 7'd20, 8'd28, 7'd20, 8'd32, 7'd20);
    do_check("plain_move", 8'd20, 7'd20, 1'b0, 1'b1);
    do_check("corner_move", 8'd156, 7'd116, 1'b0, 1'b0);

    do_check("food_eat", 8'd80, 7'd60, 1'b0, 1'b0);
    chk("food_moved", (bus.food_x == 8'd80) && (bus.food_y == 7'd60), 1'b0);

    // Abort mid-scan: no pulse, food back to its reset cell
    bus.check_start = 1'b1;
    bus.head_x      = 8'd20;
    bus.head_y      = 7'd20;
    tick();
    bus.check_start = 1'b0;
    bus.seg_valid   = 1'b1;
    bus.seg_x       = 8'd24;
    bus.seg_y       = 7'd20;
    tick();
    bus.seg_valid   = 1'b0;
    rst             = 1'b1;
    tick();
    rst             = 1'b0;
    m_fx            = 8'd80;
    m_fy            = 7'd60;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_food", {bus.food_x, 1'b0, bus.food_y}, {8'd80, 1'b0, 7'd60});
    repeat (4) tick();

    set_segs3(8'd84, 7'd60, 8'd88, 7'd60, 8'd80, 7'd60);
    do_check("dead_on_food", 8'd80, 7'd60, 1'b1, 1'b0);
    set_segs3(8'd84, 7'd60, 8'd88, 7'd60, 8'd92, 7'd60);
    do_check("food_eat2", 8'd80, 7'd60, 1'b0, 1'b0);
    set_segs3(8'd24, 7'd20, 8'd28, 7'd20, 8'd32, 7'd20);
    do_check("plain_after", 8'd20, 7'd20, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_collision_unit.md
# snake_collision_unit

Collision and food manager for the snake datapath. It sits directly upstream of the movement FSM and produces that FSM's `isDead` and `length_inc` inputs. For each candidate head position it checks for wall hits, self-hits against a streamed body walk, and food hits. On a food hit it relocates the food to a new pseudo-random grid-aligned cell.

## Interface
Parameters:
- `SCR_W`, 160: playfield width in pixels; legal x is 0..SCR_W-1.
- `SCR_H`, 120: playfield height in pixels; legal y is 0..SCR_H-1.
- `FOOD_X0`, 80: food x after reset. Must be a multiple of 4.
- `FOOD_Y0`, 60: food y after reset. Must be a multiple of 4.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.
- `MAX_TRIES`, 255: relocation attempt cap.

Ports:
- `clk` input 1: the single clock. All logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `check_start` input 1: one-cycle pulse. Samples `head_x`/`head_y` and begins a check.
- `head_x` input 8: candidate head x in pixels, 4-aligned.
- `head_y` input 7: candidate head y in pixels, 4-aligned.
- `seg_valid` input 1: the body segment on `seg_x`/`seg_y` is valid this cycle.
- `seg_x` input 8: body segment x.
- `seg_y` input 7: body segment y.
- `seg_last` input 1: qualified by `seg_valid`; marks the final body segment.
- `busy` output 1: high in every state except IDLE.
- `check_done` output 1: one-cycle pulse when the check completes.
- `is_dead` output 1: one-cycle pulse, coincident with `check_done`, when a collision is found.
- `length_inc` output 1: one-cycle pulse, coincident with `check_done`, when food is eaten.
- `food_x` output 8: current food x, registered.
- `food_y` output 7: current food y, registered.

## Operation
- Cell size is 4x4 pixels. Every coordinate this block produces has bits [1:0] = 0.
- LFSR:
  - 16-bit Fibonacci with taps 16, 14, 13, 11; shifts left.
  - Feedback is lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10] into bit 0.
  - Advances every cycle in all states, so player timing contributes entropy.
- States: IDLE, SCAN, RESOLVE, RELOCATE.
- IDLE:
  - On `check_start`, latch the head, clear the dead flag and the try counter, and go to SCAN.
  - The wall check is done at latch time: dead flag = (head_x >= SCR_W) || (head_y >= SCR_H).
  - Underflow from 0-4 wraps to 252 or 124, so it is caught as a wall hit.
- SCAN:
  - Each cycle with `seg_valid`, set the dead flag if seg == latched head.
  - `seg_valid && seg_last` moves to RESOLVE; that final segment is still compared.
  - Stays in SCAN while `seg_valid` is low; no timeout.
  - The scan always consumes the full stream, even if the dead flag is already set.
- RESOLVE (one cycle):
  - Dead flag set: pulse `check_done` and `is_dead`, go to IDLE. Food is unchanged, even if the head also equals the food.
  - Otherwise, head == food: go to RELOCATE.
  - Otherwise: pulse `check_done` only, go to IDLE.
- RELOCATE, one attempt per cycle:
  - Candidate: cx = lfsr[5:0], cy = lfsr[12:8].
  - Accept if cx < SCR_W/4, cy < SCR_H/4, and {cx,2'b00},{cy,2'b00} != latched head.
  - On accept: food <= {cx,2'b00},{cy,2'b00}; pulse `check_done` and `length_inc`; go to IDLE.
  - On reject: increment the try counter. When it reaches MAX_TRIES, load FOOD_X0/FOOD_Y0, pulse `check_done` and `length_inc`, and go to IDLE.
  - Body cells are not checked during relocation; food landing under the body is permitted.
- `check_start` outside IDLE is ignored.
- `seg_valid` outside SCAN is ignored, including the cycle of `check_start`.

## Timing
- Reset values:
  - state IDLE; lfsr = LFSR_SEED.
  - food_x = FOOD_X0; food_y = FOOD_Y0.
  - busy, check_done, is_dead and length_inc all 0.
  - Head latch, dead flag and try counter all 0.
- `rst` during any state returns to IDLE on the next edge. No pulse is emitted and a pending relocation is abandoned.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Latency:
  - `check_start` at cycle t; first segment accepted at t+1.
  - `seg_last` accepted at cycle s; RESOLVE at s+1.
  - No-food result: `check_done` is visible at s+2.
  - Food case: `check_done` is visible at s+2+k, where k >= 1 is the number of relocation attempts.
- `food_x`/`food_y` change only in the cycle `length_inc` is visible, or on reset.
- `busy` rises the cycle after `check_start` and falls in the same cycle `check_done` is visible.

## Test plan
- Reset: assert `rst` for 2 cycles -> food = (80,60), busy = 0, all pulses 0. The LFSR sequence after release starts at 16'hACE1.
- Wall hit: head (160,20), 3 segments with no match -> exactly one `check_done`+`is_dead` pulse at s+2; food unchanged. Repeat with head (252,0) from underflow -> dead.
- Self hit: head (40,40); segments (44,40), (40,40), (36,40 with last) -> `is_dead`=1, `length_inc`=0.
- Food eat: head (80,60), no segment match -> `length_inc` pulse. New food is 4-aligned, x<160, y<120 and != (80,60), and it matches a reference LFSR model.
- Plain move: head (20,20), no match -> `check_done` only, at s+2. A `check_start` pulsed while busy produces no second `check_done`.
- Reset mid-SCAN after 1 segment -> IDLE, no pulse. A following normal check behaves per the scenarios above.
